sram_bus_arbiter: RTL

// - Shares one sram-like bus between the instruction-fetch port (I) and the data-memory port (D).
// - Sits between the fetch unit / memory stage and the SoC bus bridge.
// - Holds one outstanding transaction at a time: arbitrate, address phase, data phase.
// - Routes addr_ok, data_ok and rdata back to the owning requester only.

---
 rtl/sram_bus_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sram_bus_arbiter.sv
// Two-port (fetch I / data D) arbiter onto one sram-like bus, one transaction in flight.
// Build option ARB_ROUND_ROBIN_EN: alternate I/D on contention instead of fixed D-over-I priority.
module sram_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_wen,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                bus_req,
  output logic [DATA_W/8-1:0] bus_wen,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                bus_timeout,
  output logic [1:0]          fsm_state
);

  localparam int BW = DATA_W / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t              state;
  logic                owner_d;
  logic [CW-1:0]       cnt;
  logic [BW-1:0]       lat_wen;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
`ifdef ARB_ROUND_ROBIN_EN
  logic                last_d;
`endif

  logic any_req;
  logic pick_d;
  logic in_addr;
  logic in_data;
  logic tmo_hit;
  logic done;
  logic tmo_fire;
  logic finish;
  logic addr_pulse;

  always_comb begin
    any_req = i_req | d_req;
`ifdef ARB_ROUND_ROBIN_EN
    pick_d  = d_req & (~i_req | ~last_d);
`else
    pick_d  = d_req;
`endif
    in_addr = (state == ADDR);
    in_data = (state == DATA);
    tmo_hit = (TIMEOUT > 0) && (in_addr || in_data) && (cnt == CW'(TIMEOUT));
    // A bus completion in the timeout cycle wins over the abort.
    done       = bus_data_ok && (in_data || (in_addr && bus_addr_ok));
    tmo_fire   = tmo_hit && !done;
    finish     = done || tmo_fire;
    addr_pulse = in_addr && (bus_addr_ok || tmo_fire);
  end

  // Responses are steered to the owner only; the other port sees zeros.
  assign i_addr_ok   = addr_pulse & ~owner_d;
  assign d_addr_ok   = addr_pulse & owner_d;
  assign i_data_ok   = finish & ~owner_d;
  assign d_data_ok   = finish & owner_d;
  assign i_rdata     = (done && !owner_d) ? bus_rdata : '0;
  assign d_rdata     = (done && owner_d) ? bus_rdata : '0;
  assign bus_req     = in_addr;
  assign bus_wen     = in_addr ? lat_wen : '0;
  assign bus_addr    = in_addr ? lat_addr : '0;
  assign bus_wdata   = in_addr ? lat_wdata : '0;
  assign bus_timeout = tmo_fire;
  assign fsm_state   = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner_d   <= 1'b1;
      cnt       <= '0;
      lat_wen   <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d    <= 1'b1;
`endif
    end else begin
      // Grant from IDLE, or straight from a completing cycle so back-to-back needs no bubble.
      if ((state == IDLE || finish) && any_req) begin
        state     <= ADDR;
        owner_d   <= pick_d;
        cnt       <= '0;
        lat_wen   <= pick_d ? d_wen : '0;
        lat_addr  <= pick_d ? d_addr : i_addr;
        lat_wdata <= pick_d ? d_wdata : '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d    <= pick_d;
`endif
      end else if (finish) begin
        state <= IDLE;
      end else begin
        if (in_addr && bus_addr_ok) state <= DATA;
        if (in_addr || in_data) cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
